// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
// Merges two register-file write sources into one registered write port.
//   Port A (pipeline writeback) normally wins; Port B (multicycle unit)
//   writes wait in a small FIFO and are drained when Port A is idle.
//   An accepted Port-A write kills queued Port-B entries to the same
//   register (WAW), so an older queued value never overwrites a newer one.
//   A starve counter forces a pop when Port A has held off the queue for
//   STARVE_LIM cycles.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_a_valid/o_a_ready/i_a_addr/i_a_data   Port-A request
//   i_b_valid/o_b_ready/i_b_addr/i_b_data   Port-B request
//   o_wen/o_waddr/o_wdata             registered register-file write
//   o_busy_mask                       registers targeted by live queue entries
module regfile_wr_arb #(
  parameter int N_REG      = 32,
  parameter int N_REG_ADDR = 5,
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_a_valid,
  output logic                     o_a_ready,
  input  logic [N_REG_ADDR-1:0]    i_a_addr,
  input  logic [N_REG-1:0]         i_a_data,
  input  logic                     i_b_valid,
  output logic                     o_b_ready,
  input  logic [N_REG_ADDR-1:0]    i_b_addr,
  input  logic [N_REG-1:0]         i_b_data,
  output logic                     o_wen,
  output logic [N_REG_ADDR-1:0]    o_waddr,
  output logic [N_REG-1:0]         o_wdata,
  output logic [2**N_REG_ADDR-1:0] o_busy_mask
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIM);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [AW-1:0]         wr_idx, rd_idx;
  logic [N_REG_ADDR-1:0] q_addr [QDEPTH];
  logic [N_REG-1:0]      q_data [QDEPTH];
  logic [QDEPTH-1:0]     q_live;
  logic [CW-1:0]         starve_cnt;

  logic                  empty, full;
  logic                  a_fire, b_fire, pop, push, kill;
  logic                  sel_wen;
  logic [N_REG_ADDR-1:0] sel_addr;
  logic [N_REG-1:0]      sel_data;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // Readies come from registered state only; both are held low in reset.
  assign o_a_ready = ~i_rst & (starve_cnt != STARVE_MAX);
  assign o_b_ready = ~i_rst & ~full;

  assign a_fire = i_a_valid & o_a_ready;
  assign b_fire = i_b_valid & o_b_ready;
  // An accepted Port-A write owns the output even when it targets r0.
  assign pop    = ~a_fire & ~empty;
  assign push   = b_fire & (i_b_addr != '0);
  assign kill   = a_fire & (i_a_addr != '0);

  always_comb begin
    sel_wen  = 1'b0;
    sel_addr = i_a_addr;
    sel_data = i_a_data;
    if (a_fire) begin
      sel_wen = (i_a_addr != '0);
    end else if (pop) begin
      sel_wen  = q_live[rd_idx];
      sel_addr = q_addr[rd_idx];
      sel_data = q_data[rd_idx];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_wen <= sel_wen;
      if (sel_wen) begin
        o_waddr <= sel_addr;
        o_wdata <= sel_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through live bits.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr[wr_idx] <= i_b_addr;
      q_data[wr_idx] <= i_b_data;
    end
  end

  // Live bits drop on pop so that live implies occupied. A same-cycle push
  // to the killed address is younger than the Port-A write and stays live.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_live <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (pop && (rd_idx == AW'(i))) begin
          q_live[i] <= 1'b0;
        end else if (kill && (q_addr[i] == i_a_addr)) begin
          q_live[i] <= 1'b0;
        end
      end
      if (push) q_live[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_live[i]) o_busy_mask[q_addr[i]] = 1'b1;
    end
    o_busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wr_arb.sv
module tb_regfile_wr_arb;

  localparam int N_REG      = 32;
  localparam int N_REG_ADDR = 5;
  localparam int QDEPTH     = 4;
  localparam int STARVE_LIM = 8;

  logic        i_clk, i_rst;
  logic        i_a_valid, o_a_ready, i_b_valid, o_b_ready;
  logic [4:0]  i_a_addr, i_b_addr, o_waddr;
  logic [31:0] i_a_data, i_b_data, o_wdata, o_busy_mask;
  logic        o_wen;

  regfile_wr_arb #(
    .N_REG(N_REG), .N_REG_ADDR(N_REG_ADDR), .QDEPTH(QDEPTH), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy_mask(o_busy_mask)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        live;
  } entry_t;

  entry_t q[$];
  int     cnt;
  int     n_assert = 0;
  int     n_fail   = 0;
  int     n_block  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One cycle: drive inputs, check readies/mask, advance the model, check output.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    entry_t      e;
    bit          a_rdy, b_rdy, a_f, b_f, pop, was_empty, nw;
    logic [4:0]  na;
    logic [31:0] nd;
    i_a_valid = av; i_a_addr = aa; i_a_data = ad;
    i_b_valid = bv; i_b_addr = ba; i_b_data = bd;
    #1;
    a_rdy = (cnt != STARVE_LIM);
    b_rdy = (q.size() < QDEPTH);
    chk("a_ready", {63'd0, o_a_ready}, {63'd0, a_rdy});
    chk("b_ready", {63'd0, o_b_ready}, {63'd0, b_rdy});
    chk("busy_mask", {32'd0, o_busy_mask}, {32'd0, model_mask()});
    if (!o_a_ready) n_block++;
    a_f = av && a_rdy;
    b_f = bv && b_rdy;
    was_empty = (q.size() == 0);
    pop = !a_f && !was_empty;
    nw = 1'b0; na = '0; nd = '0;
    if (a_f) begin
      nw = (aa != 0); na = aa; nd = ad;
    end else if (pop) begin
      e = q.pop_front();
      nw = e.live; na = e.addr; nd = e.data;
    end
    if (a_f && aa != 0) foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
    if (b_f && ba != 0) begin
      e.addr = ba; e.data = bd; e.live = 1'b1;
      q.push_back(e);
    end
    if (was_empty || pop) cnt = 0;
    else if (cnt < STARVE_LIM) cnt++;
    @(posedge i_clk);
    #1;
    chk("wen", {63'd0, o_wen}, {63'd0, nw});
    if (nw) begin
      chk("waddr", {59'd0, o_waddr}, {59'd0, na});
      chk("wdata", {32'd0, o_wdata}, {32'd0, nd});
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("rst_wen", {63'd0, o_wen}, 64'd0);
    chk("rst_mask", {32'd0, o_busy_mask}, 64'd0);
    chk("rst_a_ready", {63'd0, o_a_ready}, 64'd0);
    chk("rst_b_ready", {63'd0, o_b_ready}, 64'd0);
    q.delete();
    cnt = 0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    chk("rst_wen_hold", {63'd0, o_wen}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("post_rst_a_ready", {63'd0, o_a_ready}, 64'd1);
    chk("post_rst_b_ready", {63'd0, o_b_ready}, 64'd1);
  endtask

  initial begin
    i_rst = 1'b1;
    i_a_valid = 1'b0; i_a_addr = '0; i_a_data = '0;
    i_b_valid = 1'b0; i_b_addr = '0; i_b_data = '0;
    cnt = 0;
    do_reset();

    // Port A only
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
    chk("a_r3_wen", {63'd0, o_wen}, 64'd1);
    chk("a_r3_addr", {59'd0, o_waddr}, 64'd3);
    chk("a_r3_data", {32'd0, o_wdata}, 64'h11);
    step(1'b1, 5'd0, 32'h22, 1'b0, 5'd0, 32'd0);
    chk("a_r0_wen", {63'd0, o_wen}, 64'd0);
    idle(1);

    // Fill (A busy on r10 so nothing drains) then drain in order
    for (int k = 1; k <= 4; k++)
      step(1'b1, 5'd10, 32'h100 + k, 1'b1, 5'(k), 32'h200 + k);
    chk("fill_mask", {32'd0, o_busy_mask}, 64'h1E);
    chk("fill_b_ready", {63'd0, o_b_ready}, 64'd0);
    idle(5);
    chk("drain_mask", {32'd0, o_busy_mask}, 64'd0);

    // WAW kill
    step(1'b1, 5'd9, 32'h9, 1'b1, 5'd5, 32'hAA);
    step(1'b1, 5'd5, 32'hBB, 1'b0, 5'd0, 32'd0);
    chk("waw_mask", {32'd0, o_busy_mask}, 64'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("waw_killed_wen", {63'd0, o_wen}, 64'd0);
    idle(1);

    // Starvation: one queued r7 while A streams every cycle
    n_block = 0;
    step(1'b1, 5'd8, 32'h300, 1'b1, 5'd7, 32'h77);
    for (int k = 1; k <= 11; k++) step(1'b1, 5'd8, 32'h300 + k, 1'b0, 5'd0, 32'd0);
    chk("starve_block_cycles", 64'(n_block), 64'd1);
    chk("starve_mask", {32'd0, o_busy_mask}, 64'd0);
    idle(1);

    // Same-cycle conflict on r6
    step(1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2);
    chk("conflict_mask", {32'd0, o_busy_mask}, 64'h40);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("conflict_second", {32'd0, o_wdata}, 64'h2);
    idle(1);

    // Reset with three entries queued
    step(1'b1, 5'd9, 32'h1, 1'b1, 5'd11, 32'hB1);
    step(1'b1, 5'd9, 32'h2, 1'b1, 5'd12, 32'hB2);
    step(1'b1, 5'd9, 32'h3, 1'b1, 5'd13, 32'hB3);
    do_reset();
    idle(4);

    // Random traffic on a narrow address range to provoke kills and conflicts
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    idle(QDEPTH + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
